// File: rtl/bcd_sub_serial.sv
// rtl/bcd_sub_serial.sv - digit-serial packed BCD subtractor (A - B - bin), LSD first
// Optional BCD_SUB_ERR_EN adds a sticky non-BCD digit flag on port err.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  busy,
  output logic                  done
`ifdef BCD_SUB_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   k;
  logic [W-1:0]    a_sh, b_sh, res, res_next;
  logic            brw;
  logic [3:0]      ak, bk, d;
  logic signed [5:0] t;
  logic            neg;
  logic            last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operands shift right so the active digit is always in the low nibble;
  // the result fills from the top so digit 0 lands at the bottom after DIGITS steps.
  assign ak   = a_sh[3:0];
  assign bk   = b_sh[3:0];
  assign last = (k == LAST);

  always_comb begin
    t   = $signed({2'b00, ak}) - $signed({2'b00, bk}) - $signed({5'b00000, brw});
    neg = t[5];
    d   = neg ? 4'(t + 6'sd10) : t[3:0];
    res_next = res >> 4;
    res_next[W-1 -: 4] = d;
  end

`ifdef BCD_SUB_ERR_EN
  logic flag;
  logic dig_bad;
  assign dig_bad = (ak > 4'd9) || (bk > 4'd9);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      brw  <= 1'b0;
      k    <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef BCD_SUB_ERR_EN
      flag <= 1'b0;
      err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            res  <= '0;
            k    <= '0;
`ifdef BCD_SUB_ERR_EN
            flag <= 1'b0;
`endif
          end
        end
        CALC: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          brw  <= neg;
          res  <= res_next;
          k    <= k + 1'b1;
`ifdef BCD_SUB_ERR_EN
          flag <= flag | dig_bad;
`endif
          if (last) begin
            diff <= res_next;
            bout <= neg;
`ifdef BCD_SUB_ERR_EN
            err  <= flag | dig_bad;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
